// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing one memory slave between the icache (m0) and data port (m1).
// Optional watchdog for hung slave cycles is built when WB_ARB_TIMEOUT_EN is defined.
module wb_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_o,
  input  logic [2:0]  m0_cti,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  output logic [31:0] m0_dat_i,

  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_o,
  input  logic [2:0]  m1_cti,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  output logic [31:0] m1_dat_i,

  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  output logic [2:0]  s_cti,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   timeout_err;

  // A grant is held for the whole CYC tenure; last=1 after reset so m0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && (!m1_cyc || last)) begin
            state <= GRANT0;
            gnt   <= 2'b01;
          end else if (m1_cyc) begin
            state <= GRANT1;
            gnt   <= 2'b10;
          end
        end
        GRANT0: begin
          if (!m0_cyc) begin
            last <= 1'b0;
            if (m1_cyc) begin
              state <= GRANT1;
              gnt   <= 2'b10;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        GRANT1: begin
          if (!m1_cyc) begin
            last <= 1'b1;
            if (m0_cyc) begin
              state <= GRANT0;
              gnt   <= 2'b01;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Slave request mux and termination routing; terminations pass through combinationally.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = 32'h0;
    s_dat_o = 32'h0;
    s_cti   = 3'b000;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m0_rty  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    m1_rty  = 1'b0;
    case (state)
      GRANT0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb & m0_cyc & ~timeout_err;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_o = m0_dat_o;
        s_cti   = m0_cti;
        m0_ack  = s_ack;
        m0_err  = s_err | timeout_err;
        m0_rty  = s_rty;
      end
      GRANT1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb & m1_cyc & ~timeout_err;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_o = m1_dat_o;
        s_cti   = m1_cti;
        m1_ack  = s_ack;
        m1_err  = s_err | timeout_err;
        m1_rty  = s_rty;
      end
      default: begin
      end
    endcase
  end

  assign m0_dat_i = s_dat_i;
  assign m1_dat_i = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] WdLimit = 8'(TIMEOUT);

  logic [7:0] wd_count;

  // Counts stalled strobe cycles; on the limit a one-cycle error is injected toward the granted master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_count    <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE || s_ack || s_err || s_rty) begin
        wd_count <= 8'd0;
      end else if (s_stb) begin
        if (wd_count == WdLimit - 8'd1) begin
          wd_count    <= 8'd0;
          timeout_err <= 1'b1;
        end else begin
          wd_count <= wd_count + 8'd1;
        end
      end
    end
  end
`else
  // Without the watchdog TIMEOUT has no effect; it is referenced only so the parameter stays part of the interface.
  assign timeout_err = 1'b0 & (TIMEOUT == 0);
`endif

endmodule
